lcd_bus_decoder: RTL

// Receive end of the 4-bit HD44780-style LCD bus (LCD_E/RS/RW/D) driven by LCD_module.

---
 rtl/lcd_bus_decoder_if.sv | 33 +++
 rtl/lcd_bus_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_decoder_if.sv
`default_nettype none
// ============================================================================
// Module  : lcd_bus_decoder_if
// Brief   : 4-bit HD44780 bus plus the display-mirror outputs of the decoder.
// Revision: 1.0
// ============================================================================
interface lcd_bus_decoder_if;
    logic         LCD_E;
    logic         LCD_RS;
    logic         LCD_RW;
    logic [3:0]   LCD_D;
    logic [127:0] row_A;
    logic [127:0] row_B;
    logic         cmd_valid;
    logic         data_valid;
    logic [7:0]   byte_out;
    logic [6:0]   ddram_addr;
    logic         bus4_mode;
    logic         nibble_err;

    modport master (
        output LCD_E, LCD_RS, LCD_RW, LCD_D,
        input  row_A, row_B, cmd_valid, data_valid, byte_out,
               ddram_addr, bus4_mode, nibble_err
    );

    modport slave (
        input  LCD_E, LCD_RS, LCD_RW, LCD_D,
        output row_A, row_B, cmd_valid, data_valid, byte_out,
               ddram_addr, bus4_mode, nibble_err
    );
endinterface
`default_nettype wire

// File: rtl/lcd_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module  : lcd_bus_decoder
// Brief   : Snoops an HD44780 bus, rebuilds bytes and mirrors the 2x16 display.
// Revision: 1.0
// ============================================================================
module lcd_bus_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int NIB_TIMEOUT = 100000
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    lcd_bus_decoder_if.slave   bus
);

    typedef enum logic [0:0] {
        PH_HIGH = 1'b0,
        PH_LOW  = 1'b1
    } phase_t;

    localparam int              c_CW      = (NIB_TIMEOUT > 0) ? $clog2(NIB_TIMEOUT + 1) : 1;
    localparam logic [c_CW-1:0] c_TIMEOUT = c_CW'(NIB_TIMEOUT);
    localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);
    localparam logic            c_TO_EN   = (NIB_TIMEOUT != 0);
    localparam logic [127:0]    c_SPACES  = {16{8'h20}};

    // {E, RS, RW, D[3:0]} through the synchroniser chain
    logic [6:0]                  w_raw;
    logic [SYNC_STAGES-1:0][6:0] r_sync;
    logic                        w_e;
    logic                        r_e_d;
    logic                        w_strobe;
    logic                        r_rs_s;
    logic                        r_rw_s;
    logic [3:0]                  r_d_s;

    phase_t        r_phase,  w_phase_nxt;
    logic [3:0]    r_hi,     w_hi_nxt;
    logic          r_hi_rs,  w_hi_rs_nxt;
    logic          r_hi_rw,  w_hi_rw_nxt;
    logic [c_CW-1:0] r_cnt,  w_cnt_nxt;
    logic [127:0]  r_row_a,  w_row_a_nxt;
    logic [127:0]  r_row_b,  w_row_b_nxt;
    logic [6:0]    r_addr,   w_addr_nxt;
    logic          r_inc,    w_inc_nxt;
    logic          r_mode,   w_mode_nxt;
    logic [7:0]    r_byte,   w_byte_nxt;
    logic          r_cmd,    w_cmd_nxt;
    logic          r_data,   w_data_nxt;
    logic          r_err,    w_err_nxt;

    logic          w_timeout;
    logic          w_done;
    logic [7:0]    w_val;
    logic          w_is_data;
    logic          w_is_read;
    logic [6:0]    w_lsb;

    assign w_raw    = {bus.LCD_E, bus.LCD_RS, bus.LCD_RW, bus.LCD_D};
    assign w_e      = r_sync[SYNC_STAGES-1][6];
    assign w_strobe = r_e_d & ~w_e;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_e_d  <= 1'b0;
            r_rs_s <= 1'b0;
            r_rw_s <= 1'b0;
            r_d_s  <= 4'h0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw};
            r_e_d  <= w_e;
            if (w_e) begin
                r_rs_s <= r_sync[SYNC_STAGES-1][5];
                r_rw_s <= r_sync[SYNC_STAGES-1][4];
                r_d_s  <= r_sync[SYNC_STAGES-1][3:0];
            end
        end
    end

    // Line 1 occupies 0x00-0x27, line 2 0x40-0x67; the step wraps between them
    function automatic logic [6:0] f_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    always_comb begin
        w_phase_nxt = r_phase;
        w_hi_nxt    = r_hi;
        w_hi_rs_nxt = r_hi_rs;
        w_hi_rw_nxt = r_hi_rw;
        w_cnt_nxt   = '0;
        w_row_a_nxt = r_row_a;
        w_row_b_nxt = r_row_b;
        w_addr_nxt  = r_addr;
        w_inc_nxt   = r_inc;
        w_mode_nxt  = r_mode;
        w_byte_nxt  = r_byte;
        w_cmd_nxt   = 1'b0;
        w_data_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_done      = 1'b0;
        w_val       = 8'h00;
        w_is_data   = 1'b0;
        w_is_read   = 1'b0;
        w_lsb       = {~r_addr[3:0], 3'b000};

        w_timeout = c_TO_EN && (r_phase == PH_LOW) && (r_cnt == c_TIMEOUT);
        if (c_TO_EN && (r_phase == PH_LOW) && !w_timeout) begin
            w_cnt_nxt = r_cnt + c_ONE;
        end
        if (w_timeout) begin
            w_err_nxt   = 1'b1;
            w_phase_nxt = PH_HIGH;
        end

        if (w_strobe) begin
            if (!r_mode) begin
                w_done    = 1'b1;
                w_val     = {r_d_s, 4'h0};
                w_is_data = r_rs_s;
                w_is_read = r_rw_s;
            end else if ((r_phase == PH_HIGH) || w_timeout) begin
                // a strobe coinciding with the timeout starts a fresh byte
                w_phase_nxt = PH_LOW;
                w_hi_nxt    = r_d_s;
                w_hi_rs_nxt = r_rs_s;
                w_hi_rw_nxt = r_rw_s;
                w_cnt_nxt   = '0;
            end else begin
                w_phase_nxt = PH_HIGH;
                w_done      = 1'b1;
                w_val       = {r_hi, r_d_s};
                w_is_data   = r_hi_rs;
                w_is_read   = r_hi_rw;
            end
        end

        if (w_done && !w_is_read) begin
            w_byte_nxt = w_val;
            if (w_is_data) begin
                w_data_nxt = 1'b1;
                if (r_addr[6:4] == 3'b000) begin
                    w_row_a_nxt[w_lsb +: 8] = w_val;
                end else if (r_addr[6:4] == 3'b100) begin
                    w_row_b_nxt[w_lsb +: 8] = w_val;
                end
                w_addr_nxt = f_step(r_addr, r_inc);
            end else begin
                w_cmd_nxt = 1'b1;
                if (w_val[7]) begin
                    w_addr_nxt = w_val[6:0];
                end else if (w_val[6]) begin
                    w_addr_nxt = r_addr;
                end else if (w_val[5]) begin
                    w_mode_nxt  = ~w_val[4];
                    w_phase_nxt = PH_HIGH;
                end else if (w_val[7:1] == 7'b0000001) begin
                    w_addr_nxt = 7'h00;
                end else if (w_val == 8'h01) begin
                    w_row_a_nxt = c_SPACES;
                    w_row_b_nxt = c_SPACES;
                    w_addr_nxt  = 7'h00;
                    w_inc_nxt   = 1'b1;
                end else if (w_val[7:2] == 6'b000001) begin
                    w_inc_nxt = w_val[1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= PH_HIGH;
            r_hi    <= 4'h0;
            r_hi_rs <= 1'b0;
            r_hi_rw <= 1'b0;
            r_cnt   <= '0;
            r_row_a <= c_SPACES;
            r_row_b <= c_SPACES;
            r_addr  <= 7'h00;
            r_inc   <= 1'b1;
            r_mode  <= 1'b0;
            r_byte  <= 8'h00;
            r_cmd   <= 1'b0;
            r_data  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_hi    <= w_hi_nxt;
            r_hi_rs <= w_hi_rs_nxt;
            r_hi_rw <= w_hi_rw_nxt;
            r_cnt   <= w_cnt_nxt;
            r_row_a <= w_row_a_nxt;
            r_row_b <= w_row_b_nxt;
            r_addr  <= w_addr_nxt;
            r_inc   <= w_inc_nxt;
            r_mode  <= w_mode_nxt;
            r_byte  <= w_byte_nxt;
            r_cmd   <= w_cmd_nxt;
            r_data  <= w_data_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.row_A      = r_row_a;
    assign bus.row_B      = r_row_b;
    assign bus.cmd_valid  = r_cmd;
    assign bus.data_valid = r_data;
    assign bus.byte_out   = r_byte;
    assign bus.ddram_addr = r_addr;
    assign bus.bus4_mode  = r_mode;
    assign bus.nibble_err = r_err;

endmodule
`default_nettype wire
